// File: rtl/clk_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_gen_if                                                |
// | Purpose  : Configuration handshake and divided-clock outputs of      |
// |            clk_gen, bundled with requester/generator modports.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface clk_gen_if #(
  parameter int NUM_OUT = 2,
  parameter int DIV_W   = 8,
  parameter int CW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CW-1:0]      cfg_chan;
  logic [DIV_W-1:0]   cfg_div;
  logic [DIV_W-1:0]   cfg_phase;
  logic [NUM_OUT-1:0] outclk;
  logic [NUM_OUT-1:0] outclk_en;
  logic               locked;

  // Requester side: issues configuration, observes clocks and lock.
  modport master (
    output cfg_valid, cfg_chan, cfg_div, cfg_phase,
    input  cfg_ready, outclk, outclk_en, locked
  );

  // Generator side.
  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, cfg_phase,
    output cfg_ready, outclk, outclk_en, locked
  );
endinterface
`default_nettype wire

// File: rtl/clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_gen                                                   |
// | Purpose  : NUM_OUT divided clock/enable channels from one reference  |
// |            clock, each with programmable divide and phase; any       |
// |            reconfiguration forces a phase-aligned relock.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module clk_gen #(
  parameter int NUM_OUT     = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  wire logic  refclk,
  input  wire logic  rst_n,
  clk_gen_if.slave   bus
);

  localparam int CW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [LCW-1:0]   C_LOCK_LAST   = LCW'(LOCK_CYCLES - 1);
  localparam logic [CW:0]      C_NUM_OUT     = (CW + 1)'(NUM_OUT);
  localparam logic [DIV_W-1:0] C_DEFAULT_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] C_MIN_DIV     = DIV_W'(2);
  localparam logic [DIV_W-1:0] C_ONE         = DIV_W'(1);

  typedef enum logic [0:0] {
    ST_LOCKING = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  state_t             r_state,      w_state_nxt;
  logic [LCW-1:0]     r_lock_cnt,   w_lock_cnt_nxt;
  logic               r_locked,     w_locked_nxt;
  logic [NUM_OUT-1:0] r_outclk,     w_outclk_nxt;
  logic [NUM_OUT-1:0] r_outclk_en,  w_outclk_en_nxt;
  logic [DIV_W-1:0]   r_div   [NUM_OUT];
  logic [DIV_W-1:0]   r_phase [NUM_OUT];
  logic [DIV_W-1:0]   r_cnt   [NUM_OUT];
  logic [DIV_W-1:0]   w_div_nxt   [NUM_OUT];
  logic [DIV_W-1:0]   w_phase_nxt [NUM_OUT];
  logic [DIV_W-1:0]   w_cnt_nxt   [NUM_OUT];

  logic [DIV_W-1:0]   w_eff_div;
  logic [DIV_W-1:0]   w_eff_phase;
  logic               w_chan_ok;
  logic               w_cfg_hit;
  logic               w_cfg_drop;

  // High for the first ceil(div/2) counts of a period; the extra bit keeps
  // div+1 from overflowing at the maximum ratio.
  function automatic logic f_high(input logic [DIV_W-1:0] cnt,
                                  input logic [DIV_W-1:0] div);
    logic [DIV_W:0] half;
    half = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return ({1'b0, cnt} < half);
  endfunction

  // Ratios below 2 cannot toggle, so they become 2; the phase must be a
  // legal count of the (clamped) ratio.
  assign w_eff_div   = (bus.cfg_div < C_MIN_DIV) ? C_MIN_DIV : bus.cfg_div;
  assign w_eff_phase = (bus.cfg_phase >= w_eff_div) ? (w_eff_div - C_ONE)
                                                    : bus.cfg_phase;

  // Out-of-range channels are consumed without disturbing the running clocks.
  assign w_chan_ok  = ({1'b0, bus.cfg_chan} < C_NUM_OUT);
  assign w_cfg_hit  = (r_state == ST_LOCKED) && bus.cfg_valid && w_chan_ok;
  assign w_cfg_drop = (r_state == ST_LOCKED) && bus.cfg_valid && !w_chan_ok;

  // State, shadow and output registers; reset restores the default ratio.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOCKING;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
      r_outclk    <= '0;
      r_outclk_en <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        r_div[i]   <= C_DEFAULT_DIV;
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_locked    <= w_locked_nxt;
      r_outclk    <= w_outclk_nxt;
      r_outclk_en <= w_outclk_en_nxt;
      for (int i = 0; i < NUM_OUT; i++) begin
        r_div[i]   <= w_div_nxt[i];
        r_phase[i] <= w_phase_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Lock sequencing, config capture and per-channel count/decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_locked_nxt    = r_locked;
    w_outclk_nxt    = r_outclk;
    w_outclk_en_nxt = r_outclk_en;
    w_div_nxt       = r_div;
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;

    unique case (r_state)
      ST_LOCKING: begin
        w_locked_nxt    = 1'b0;
        w_outclk_nxt    = '0;
        w_outclk_en_nxt = '0;
        if (r_lock_cnt == C_LOCK_LAST) begin
          // Every channel starts from its phase on this same edge.
          w_state_nxt    = ST_LOCKED;
          w_locked_nxt   = 1'b1;
          w_lock_cnt_nxt = '0;
          for (int i = 0; i < NUM_OUT; i++) begin
            w_cnt_nxt[i]       = r_phase[i];
            w_outclk_nxt[i]    = f_high(r_phase[i], r_div[i]);
            w_outclk_en_nxt[i] = (r_phase[i] == '0);
          end
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
        end
      end

      ST_LOCKED: begin
        if (w_cfg_hit) begin
          w_state_nxt     = ST_LOCKING;
          w_lock_cnt_nxt  = '0;
          w_locked_nxt    = 1'b0;
          w_outclk_nxt    = '0;
          w_outclk_en_nxt = '0;
          for (int i = 0; i < NUM_OUT; i++) begin
            w_cnt_nxt[i] = '0;
            if (bus.cfg_chan == CW'(i)) begin
              w_div_nxt[i]   = w_eff_div;
              w_phase_nxt[i] = w_eff_phase;
            end
          end
        end else begin
          // Free-running counters; a dropped request falls through here too.
          for (int i = 0; i < NUM_OUT; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] == (r_div[i] - C_ONE)) ? '0
                                                            : (r_cnt[i] + C_ONE);
            w_outclk_nxt[i]    = f_high(w_cnt_nxt[i], r_div[i]);
            w_outclk_en_nxt[i] = (w_cnt_nxt[i] == '0);
          end
        end
      end

      default: begin
        w_state_nxt = ST_LOCKING;
      end
    endcase
  end

  assign bus.cfg_ready = r_locked;
  assign bus.locked    = r_locked;
  assign bus.outclk    = r_outclk;
  assign bus.outclk_en = r_outclk_en;

  logic w_unused;
  assign w_unused = w_cfg_drop;

endmodule
`default_nettype wire

// File: tb/tb_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_clk_gen                                                |
// | Purpose  : Directed self-checking bench for clk_gen (3 channels so   |
// |            that an out-of-range channel number is representable).    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_clk_gen;
  localparam int NUM_OUT     = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 8;
  localparam int DEFAULT_DIV = 2;

  logic refclk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  clk_gen_if #(.NUM_OUT(NUM_OUT), .DIV_W(DIV_W)) bus ();

  clk_gen #(
    .NUM_OUT    (NUM_OUT),
    .DIV_W      (DIV_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // One-edge configuration request (caller ensures cfg_ready is high).
  task automatic cfg_issue(input int ch, input int d, input int p);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = 2'(ch);
    bus.cfg_div   = 8'(d);
    bus.cfg_phase = 8'(p);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // Count low-lock cycles until locked rises (bounded), noting any output
  // activity while not locked.
  task automatic lock_wait(output int lows, output bit dirty);
    lows  = 0;
    dirty = 1'b0;
    while (bus.locked !== 1'b1 && lows < 40) begin
      if (bus.outclk !== 3'b000 || bus.outclk_en !== 3'b000 || bus.cfg_ready !== 1'b0)
        dirty = 1'b1;
      lows++;
      tick();
    end
  endtask

  task automatic test_reset();
    int lows;
    bit dirty;
    logic [2:0] eo [4] = '{3'b111, 3'b000, 3'b111, 3'b000};
    rst_n         = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_chan  = '0;
    bus.cfg_div   = '0;
    bus.cfg_phase = '0;
    #3;
    n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b want=0", bus.locked); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", bus.cfg_ready); end
    n_cmp++; if (bus.outclk !== 3'b000) begin n_fail++; $display("FAIL reset_outclk got=%b want=000", bus.outclk); end
    n_cmp++; if (bus.outclk_en !== 3'b000) begin n_fail++; $display("FAIL reset_en got=%b want=000", bus.outclk_en); end
    tick(); tick();
    rst_n = 1'b1;
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL reset_lock_cycles got=%0d want=8", lows); end
    n_cmp++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL reset_lock_quiet got=%b want=0", dirty); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_up got=%b want=1", bus.cfg_ready); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.outclk !== eo[k]) begin n_fail++; $display("FAIL reset_outclk[%0d] got=%b want=%b", k, bus.outclk, eo[k]); end
      n_cmp++; if (bus.outclk_en !== eo[k]) begin n_fail++; $display("FAIL reset_en[%0d] got=%b want=%b", k, bus.outclk_en, eo[k]); end
      tick();
    end
  endtask

  task automatic test_div5();
    int lows;
    bit dirty;
    logic [2:0] eo [10] = '{3'b111, 3'b010, 3'b111, 3'b000, 3'b101,
                           3'b010, 3'b111, 3'b010, 3'b101, 3'b000};
    logic [2:0] ee [10] = '{3'b111, 3'b000, 3'b101, 3'b000, 3'b101,
                           3'b010, 3'b101, 3'b000, 3'b101, 3'b000};
    cfg_issue(1, 5, 0);
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL div5_ready_drop got=%b want=0", bus.cfg_ready); end
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL div5_lock_cycles got=%0d want=8", lows); end
    n_cmp++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL div5_lock_quiet got=%b want=0", dirty); end
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (bus.outclk !== eo[k]) begin n_fail++; $display("FAIL div5_outclk[%0d] got=%b want=%b", k, bus.outclk, eo[k]); end
      n_cmp++; if (bus.outclk_en !== ee[k]) begin n_fail++; $display("FAIL div5_en[%0d] got=%b want=%b", k, bus.outclk_en, ee[k]); end
      tick();
    end
  endtask

  task automatic test_phase();
    int lows;
    bit dirty;
    logic eo [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ee [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg_issue(0, 4, 2);
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL phase_lock_cycles got=%0d want=8", lows); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (bus.outclk[0] !== eo[k]) begin n_fail++; $display("FAIL phase_outclk0[%0d] got=%b want=%b", k, bus.outclk[0], eo[k]); end
      n_cmp++; if (bus.outclk_en[0] !== ee[k]) begin n_fail++; $display("FAIL phase_en0[%0d] got=%b want=%b", k, bus.outclk_en[0], ee[k]); end
      tick();
    end
  endtask

  task automatic test_clamp();
    int lows;
    bit dirty;
    logic e0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic e1 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic n1 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    cfg_issue(0, 1, 0);
    lock_wait(lows, dirty);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.outclk[0] !== e0[k]) begin n_fail++; $display("FAIL clamp_div_outclk0[%0d] got=%b want=%b", k, bus.outclk[0], e0[k]); end
      n_cmp++; if (bus.outclk_en[0] !== e0[k]) begin n_fail++; $display("FAIL clamp_div_en0[%0d] got=%b want=%b", k, bus.outclk_en[0], e0[k]); end
      tick();
    end
    cfg_issue(1, 3, 7);
    lock_wait(lows, dirty);
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (bus.outclk[1] !== e1[k]) begin n_fail++; $display("FAIL clamp_ph_outclk1[%0d] got=%b want=%b", k, bus.outclk[1], e1[k]); end
      n_cmp++; if (bus.outclk_en[1] !== n1[k]) begin n_fail++; $display("FAIL clamp_ph_en1[%0d] got=%b want=%b", k, bus.outclk_en[1], n1[k]); end
      tick();
    end
  endtask

  // ch0 div2/ph0, ch1 div3/ph2, ch2 div2/ph0 at this point.
  task automatic test_bad_chan();
    int lows;
    bit dirty;
    logic [2:0] eo [6] = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b111, 3'b010};
    logic [2:0] ee [6] = '{3'b101, 3'b010, 3'b101, 3'b000, 3'b111, 3'b000};
    cfg_issue(2, 2, 0);
    lock_wait(lows, dirty);
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL badch_locked[%0d] got=%b want=1", k, bus.locked); end
      n_cmp++; if (bus.outclk !== eo[k]) begin n_fail++; $display("FAIL badch_outclk[%0d] got=%b want=%b", k, bus.outclk, eo[k]); end
      n_cmp++; if (bus.outclk_en !== ee[k]) begin n_fail++; $display("FAIL badch_en[%0d] got=%b want=%b", k, bus.outclk_en, ee[k]); end
      if (k == 0) begin
        cfg_issue(3, 5, 1);
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    int lows;
    bit dirty;
    logic e0 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic e1 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = 2'd0;
    bus.cfg_div   = 8'd3;
    bus.cfg_phase = 8'd0;
    tick();
    bus.cfg_chan  = 2'd1;
    bus.cfg_div   = 8'd4;
    bus.cfg_phase = 8'd1;
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL b2b_first_lock got=%0d want=8", lows); end
    n_cmp++; if (dirty !== 1'b0) begin n_fail++; $display("FAIL b2b_held_quiet got=%b want=0", dirty); end
    tick();
    bus.cfg_valid = 1'b0;
    n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept got=%b want=0", bus.locked); end
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL b2b_second_lock got=%0d want=8", lows); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.outclk[0] !== e0[k]) begin n_fail++; $display("FAIL b2b_outclk0[%0d] got=%b want=%b", k, bus.outclk[0], e0[k]); end
      n_cmp++; if (bus.outclk[1] !== e1[k]) begin n_fail++; $display("FAIL b2b_outclk1[%0d] got=%b want=%b", k, bus.outclk[1], e1[k]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    bit dirty;
    int guard;
    logic [2:0] eo [2] = '{3'b111, 3'b000};
    guard = 0;
    while (bus.outclk === 3'b000 && guard < 5) begin
      guard++;
      tick();
    end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.outclk !== 3'b000) begin n_fail++; $display("FAIL midrun_async_outclk got=%b want=000", bus.outclk); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL midrun_async_locked got=%b want=0", bus.locked); end
    tick();
    rst_n = 1'b1;
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL midrun_relock got=%0d want=8", lows); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (bus.outclk !== eo[k]) begin n_fail++; $display("FAIL midrun_outclk[%0d] got=%b want=%b", k, bus.outclk, eo[k]); end
      n_cmp++; if (bus.outclk_en !== eo[k]) begin n_fail++; $display("FAIL midrun_en[%0d] got=%b want=%b", k, bus.outclk_en, eo[k]); end
      tick();
    end
    cfg_issue(1, 5, 0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL midlock_async_locked got=%b want=0", bus.locked); end
    tick();
    rst_n = 1'b1;
    lock_wait(lows, dirty);
    n_cmp++; if (lows != 8) begin n_fail++; $display("FAIL midlock_relock got=%0d want=8", lows); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (bus.outclk !== eo[k]) begin n_fail++; $display("FAIL midlock_outclk[%0d] got=%b want=%b", k, bus.outclk, eo[k]); end
      n_cmp++; if (bus.outclk_en !== eo[k]) begin n_fail++; $display("FAIL midlock_en[%0d] got=%b want=%b", k, bus.outclk_en, eo[k]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_div5();
    test_phase();
    test_clamp();
    test_bad_chan();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
